// File: rtl/cw305_pulpino_mailbox.sv
// Core-side mailbox between the PULPino APB bus and the USB register bank, in the crypto_clk domain.
// Host words arrive through an RX FIFO; a single TX word goes back. Toggle flags carry the handshake.
module cw305_pulpino_mailbox #(
    parameter int pRX_DEPTH = 4,
    parameter int pADDR_W   = 12
) (
    input  logic               crypto_clk,
    input  logic               reset_i,
    input  logic [pADDR_W-1:0] PADDR,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    input  logic [31:0]        I_usb_to_pulpino,
    input  logic [31:0]        I_ext_to_pulpino_flags,
    output logic [31:0]        O_pulpino_to_usb,
    output logic [31:0]        O_pulpino_to_ext_flags,
    output logic               O_irq
);

    localparam int PTR_W = $clog2(pRX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(pRX_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_WAIT = 1'b1;

    logic [1:0]       flag_edge;
    logic [0:0]       rx_state_reg, rx_state_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      rx_mem [pRX_DEPTH];
    logic [31:0]      tx_data_reg;
    logic [1:0]       flags_out_reg;
    logic [1:0]       ctrl_reg;
    logic             tx_busy_reg, tx_busy_next;
    logic             err_reg, err_next;
    logic             irq_reg;
    logic             push, pop, rx_err;
    logic             access, rd_rx, wr_tx, wr_ctrl, tx_accept, tx_reject;
    logic             rx_empty, rx_full;
    logic [1:0]       reg_sel;
    logic [31:0]      status;
    logic             unused_bits;

    // Only the two handshake bits cross domains; each gets a 2-flop sync plus an edge-detect flop.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_flag_sync
        (* ASYNC_REG = "TRUE" *) logic sync1_reg;
        (* ASYNC_REG = "TRUE" *) logic sync2_reg;
        logic prev_reg;
        always_ff @(posedge crypto_clk or posedge reset_i) begin
            if (reset_i) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
                prev_reg  <= 1'b0;
            end else begin
                sync1_reg <= I_ext_to_pulpino_flags[gi];
                sync2_reg <= sync1_reg;
                prev_reg  <= sync2_reg;
            end
        end
        assign flag_edge[gi] = sync2_reg ^ prev_reg;
    end

    assign unused_bits = ^{PADDR[pADDR_W-1:4], PADDR[1:0], I_ext_to_pulpino_flags[31:2]};

    assign reg_sel   = PADDR[3:2];
    assign access    = PSEL & PENABLE;
    assign rd_rx     = access & ~PWRITE & (reg_sel == 2'd1);
    assign wr_tx     = access &  PWRITE & (reg_sel == 2'd2);
    assign wr_ctrl   = access &  PWRITE & (reg_sel == 2'd3);
    assign rx_empty  = (count_reg == '0);
    assign rx_full   = (count_reg == DEPTH);
    assign pop       = rd_rx & ~rx_empty;
    assign tx_accept = wr_tx & ~tx_busy_reg;
    assign tx_reject = wr_tx &  tx_busy_reg;

    // A word that arrives while full is held on the host bus (unacked) until a pop frees a slot.
    always_comb begin
        push          = 1'b0;
        rx_err        = 1'b0;
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            RX_IDLE: begin
                if (flag_edge[0]) begin
                    if (!rx_full) push = 1'b1;
                    else          rx_state_next = RX_WAIT;
                end
            end
            default: begin
                if (flag_edge[0]) rx_err = 1'b1;
                if (!rx_full) begin
                    push          = 1'b1;
                    rx_state_next = RX_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        tx_busy_next = tx_busy_reg;
        if (flag_edge[1]) tx_busy_next = 1'b0;
        if (tx_accept)    tx_busy_next = 1'b1;
    end

    always_comb begin
        err_next = err_reg;
        if (wr_ctrl && PWDATA[31]) err_next = 1'b0;
        if (rx_err || tx_reject || (flag_edge[1] && !tx_busy_reg)) err_next = 1'b1;
    end

    always_ff @(posedge crypto_clk) begin
        if (push) rx_mem[wr_ptr_reg] <= I_usb_to_pulpino;
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            rx_state_reg  <= RX_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            tx_data_reg   <= '0;
            flags_out_reg <= '0;
            tx_busy_reg   <= 1'b0;
            err_reg       <= 1'b0;
            ctrl_reg      <= '0;
            irq_reg       <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            if (push) begin
                wr_ptr_reg       <= wr_ptr_reg + PTR_ONE;
                flags_out_reg[1] <= ~flags_out_reg[1];
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
            if (tx_accept) begin
                tx_data_reg      <= PWDATA;
                flags_out_reg[0] <= ~flags_out_reg[0];
            end
            tx_busy_reg <= tx_busy_next;
            err_reg     <= err_next;
            if (wr_ctrl) ctrl_reg <= PWDATA[1:0];
            irq_reg <= (ctrl_reg[0] & ~rx_empty) | (ctrl_reg[1] & ~tx_busy_reg) | err_reg;
        end
    end

    assign status = {16'b0, 8'(count_reg), 3'b0, (rx_state_reg == RX_WAIT),
                     err_reg, tx_busy_reg, rx_full, ~rx_empty};

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (reg_sel)
                2'd0:    PRDATA = status;
                2'd1:    PRDATA = rx_empty ? 32'b0 : rx_mem[rd_ptr_reg];
                2'd3:    PRDATA = {30'b0, ctrl_reg};
                default: PRDATA = '0;
            endcase
        end
    end

    assign PREADY                 = 1'b1;
    assign PSLVERR                = (rd_rx & rx_empty) | tx_reject;
    assign O_pulpino_to_usb       = tx_data_reg;
    assign O_pulpino_to_ext_flags = {30'b0, flags_out_reg};
    assign O_irq                  = irq_reg;

endmodule
